// File: rtl/wm8731_cfg_pkg.sv
// wm8731_cfg_pkg
//   Shared definitions for the WM8731 configuration sequencer:
//   - control-word field widths (7-bit register address, 9-bit data)
//   - default codec write address
//   - default power-up register table (16-bit {reg, data} words)
//   - sequencer state encoding
package wm8731_cfg_pkg;

  localparam int REG_W  = 7;
  localparam int DATA_W = 9;
  localparam int WORD_W = REG_W + DATA_W;

  localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;

  // Register R15 (reset) goes first; R9 (activate) must be written last.
  localparam int TABLE_LEN = 11;
  localparam logic [WORD_W-1:0] CFG_TABLE [TABLE_LEN] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201
  };

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_LOAD,
    ST_PREP,
    ST_XFER,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

endpackage

// File: rtl/wm8731_reg_rom.sv
// wm8731_reg_rom
//   Combinational lookup of the default configuration table.
//   Ports:
//     index  in   4   table index
//     word   out  16  {reg[6:0], data[8:0]}; 16'h0000 for out-of-range indices
module wm8731_reg_rom
  import wm8731_cfg_pkg::*;
(
  input  logic [3:0]        index,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    if (int'(index) < TABLE_LEN) begin
      word = CFG_TABLE[index];
    end
  end

endmodule

// File: rtl/wm8731_cfg_ctrl.sv
// wm8731_cfg_ctrl
//   Power-up configuration sequencer for the WM8731 control port. Waits
//   PWR_DLY cycles, writes the register table through the 24-bit I2C write
//   engine (start / tr_end / ack handshake), then serves single-register
//   runtime updates. Reports sticky cfg_done or cfg_err.
//   Optional feature: define I2C_RETRY_EN to retry a failed write up to
//   MAX_RETRY extra times; without it the first failure is terminal.
//   Ports:
//     clock_i2c  in   1   engine clock
//     reset_n    in   1   asynchronous active-low reset
//     i2c_start  out  1   engine start (low clears engine, high runs a transfer)
//     i2c_data   out  24  {DEV_ADDR, reg[6:0], data[8:0]}
//     tr_end     in   1   engine end-of-transfer
//     ack        in   1   1 = at least one NACK, valid with tr_end
//     upd_valid  in   1   runtime update request
//     upd_data   in   16  {reg[6:0], data[8:0]} for the update
//     upd_ready  out  1   idle in DONE, update accepted
//     cfg_done   out  1   table written (sticky)
//     cfg_err    out  1   unrecoverable failure (sticky)
//     cfg_index  out  4   current table index
module wm8731_cfg_ctrl
  import wm8731_cfg_pkg::*;
#(
  parameter int         PWR_DLY      = 1000,
  parameter logic [7:0] DEV_ADDR     = DEV_ADDR_DEFAULT,
  parameter int         NUM_REGS     = 11,
  parameter int         MAX_RETRY    = 3,
  parameter int         XFER_TIMEOUT = 48
)(
  input  logic              clock_i2c,
  input  logic              reset_n,
  output logic              i2c_start,
  output logic [23:0]       i2c_data,
  input  logic              tr_end,
  input  logic              ack,
  input  logic              upd_valid,
  input  logic [WORD_W-1:0] upd_data,
  output logic              upd_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [3:0]        cfg_index
);

  // The retry counter is 4 bits wide and the index is 4 bits wide.
  if (MAX_RETRY < 0 || MAX_RETRY > 15 || NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_params
    $error("wm8731_cfg_ctrl: MAX_RETRY must be 0..15 and NUM_REGS 1..16");
  end

  localparam logic [15:0] DLY_LAST = 16'(PWR_DLY - 1);
  localparam logic [7:0]  TMO_LAST = 8'(XFER_TIMEOUT - 1);
  localparam logic [3:0]  IDX_LAST = 4'(NUM_REGS - 1);

  cfg_state_e        state_q, state_d;
  logic [15:0]       dly_cnt_q, dly_cnt_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic              prep_cnt_q, prep_cnt_d;
  logic              fail_q, fail_d;
  logic              upd_mode_q, upd_mode_d;
  logic [WORD_W-1:0] upd_lat_q, upd_lat_d;
  logic              i2c_start_q, i2c_start_d;
  logic [23:0]       i2c_data_q, i2c_data_d;
  logic              upd_ready_q, upd_ready_d;
  logic              cfg_done_q, cfg_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [3:0]        cfg_index_q, cfg_index_d;
`ifdef I2C_RETRY_EN
  logic [3:0]        retry_cnt_q, retry_cnt_d;
`endif

  logic [WORD_W-1:0] rom_word;

  wm8731_reg_rom u_rom (
    .index (cfg_index_q),
    .word  (rom_word)
  );

  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    prep_cnt_d  = prep_cnt_q;
    fail_d      = fail_q;
    upd_mode_d  = upd_mode_q;
    upd_lat_d   = upd_lat_q;
    i2c_data_d  = i2c_data_q;
    cfg_done_d  = cfg_done_q;
    cfg_err_d   = cfg_err_q;
    cfg_index_d = cfg_index_q;
`ifdef I2C_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif

    case (state_q)
      ST_PWR_WAIT: begin
        if (dly_cnt_q == DLY_LAST) state_d = ST_LOAD;
        else                       dly_cnt_d = dly_cnt_q + 16'd1;
      end
      ST_LOAD: begin
        i2c_data_d = upd_mode_q ? {DEV_ADDR, upd_lat_q} : {DEV_ADDR, rom_word};
        prep_cnt_d = 1'b0;
        state_d    = ST_PREP;
      end
      ST_PREP: begin
        // Two cycles of start low zero the engine's bit counter and tr_end.
        if (prep_cnt_q) begin
          tmo_cnt_d = '0;
          state_d   = ST_XFER;
        end else begin
          prep_cnt_d = 1'b1;
        end
      end
      ST_XFER: begin
        // ack is only meaningful alongside tr_end, so capture it here.
        if (tr_end) begin
          fail_d  = ack;
          state_d = ST_CHECK;
        end else if (tmo_cnt_q == TMO_LAST) begin
          fail_d  = 1'b1;
          state_d = ST_CHECK;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        if (!fail_q) begin
`ifdef I2C_RETRY_EN
          retry_cnt_d = '0;
`endif
          if (upd_mode_q) begin
            upd_mode_d = 1'b0;
            state_d    = ST_DONE;
          end else if (cfg_index_q == IDX_LAST) begin
            cfg_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cfg_index_d = cfg_index_q + 4'd1;
            state_d     = ST_LOAD;
          end
        end else begin
`ifdef I2C_RETRY_EN
          // Retry re-enters PREP so i2c_data is resent unchanged.
          if (int'(retry_cnt_q) < MAX_RETRY) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            prep_cnt_d  = 1'b0;
            state_d     = ST_PREP;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = ST_ERROR;
          end
`else
          cfg_err_d = 1'b1;
          state_d   = ST_ERROR;
`endif
        end
      end
      ST_DONE: begin
        if (upd_valid && upd_ready_q) begin
          upd_lat_d  = upd_data;
          upd_mode_d = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        cfg_err_d = 1'b1;
        state_d   = ST_ERROR;
      end
    endcase

    // Outputs follow the next state so they change together with it.
    i2c_start_d = (state_d == ST_XFER);
    upd_ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PWR_WAIT;
      dly_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      prep_cnt_q  <= 1'b0;
      fail_q      <= 1'b0;
      upd_mode_q  <= 1'b0;
      upd_lat_q   <= '0;
      i2c_start_q <= 1'b0;
      i2c_data_q  <= '0;
      upd_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_index_q <= '0;
`ifdef I2C_RETRY_EN
      retry_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      prep_cnt_q  <= prep_cnt_d;
      fail_q      <= fail_d;
      upd_mode_q  <= upd_mode_d;
      upd_lat_q   <= upd_lat_d;
      i2c_start_q <= i2c_start_d;
      i2c_data_q  <= i2c_data_d;
      upd_ready_q <= upd_ready_d;
      cfg_done_q  <= cfg_done_d;
      cfg_err_q   <= cfg_err_d;
      cfg_index_q <= cfg_index_d;
`ifdef I2C_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
`endif
    end
  end

  assign i2c_start = i2c_start_q;
  assign i2c_data  = i2c_data_q;
  assign upd_ready = upd_ready_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_index = cfg_index_q;

endmodule

// File: tb/tb_wm8731_cfg_ctrl.sv
`timescale 1ns/1ps
module tb_wm8731_cfg_ctrl;

  localparam int PWR_DLY      = 1000;
  localparam int NUM_REGS     = 11;
  localparam int MAX_RETRY    = 3;
  localparam int XFER_TIMEOUT = 48;
`ifdef I2C_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif
  localparam logic [7:0] DEV = 8'h34;
  localparam int OK = 0, NACK = 1, TMO = 2;

  localparam logic [15:0] TBL [NUM_REGS] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E02, 16'h1000, 16'h1201
  };

  logic        clock_i2c = 1'b0;
  logic        reset_n   = 1'b0;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        tr_end    = 1'b0;
  logic        ack       = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data  = 16'h0;
  logic        upd_ready, cfg_done, cfg_err;
  logic [3:0]  cfg_index;

  always #5 clock_i2c = ~clock_i2c;

  wm8731_cfg_ctrl #(
    .PWR_DLY      (PWR_DLY),
    .DEV_ADDR     (DEV),
    .NUM_REGS     (NUM_REGS),
    .MAX_RETRY    (MAX_RETRY),
    .XFER_TIMEOUT (XFER_TIMEOUT)
  ) dut (
    .clock_i2c (clock_i2c),
    .reset_n   (reset_n),
    .i2c_start (i2c_start),
    .i2c_data  (i2c_data),
    .tr_end    (tr_end),
    .ack       (ack),
    .upd_valid (upd_valid),
    .upd_data  (upd_data),
    .upd_ready (upd_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cfg_index (cfg_index)
  );

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- I2C write engine model ----------------
  logic [23:0] att_data[$];
  int          att_out[$];
  int          att_hi[$];
  int          stab_err = 0;
  bit          eng_busy = 0;
  int          eng_cnt = 0, eng_lat = 0, eng_out = 0, eng_r = 0;
  logic [23:0] eng_dat = '0;
  bit          rand_mode = 0;
  logic [15:0] tgt_word = '0;
  int          tgt_kind = OK, tgt_left = 0, fix_lat = 34;

  always @(negedge clock_i2c) begin
    if (i2c_start === 1'b1) begin
      if (!eng_busy) begin
        eng_busy = 1;
        eng_cnt  = 0;
        eng_dat  = i2c_data;
        eng_out  = OK;
        if (rand_mode) begin
          eng_r   = $urandom_range(0, 99);
          eng_out = (eng_r < 8) ? NACK : (eng_r < 11) ? TMO : OK;
          eng_lat = $urandom_range(1, 40);
        end else begin
          eng_lat = fix_lat;
          if (i2c_data[15:0] == tgt_word && tgt_left > 0) begin
            eng_out = tgt_kind;
            tgt_left--;
          end
        end
        att_data.push_back(i2c_data);
        att_out.push_back(eng_out);
        att_hi.push_back(0);
      end else if (i2c_data !== eng_dat) begin
        stab_err++;
      end
      eng_cnt++;
      if (att_hi.size() > 0) att_hi[att_hi.size()-1] = eng_cnt;
      if (eng_out != TMO && eng_cnt == eng_lat) begin
        tr_end = 1'b1;
        ack    = (eng_out == NACK);
      end
    end else begin
      eng_busy = 0;
      tr_end   = 1'b0;
      ack      = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input string tag);
    @(negedge clock_i2c);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, " rst start"}, {31'd0, i2c_start}, 32'd0);
    chk({tag, " rst data"}, {8'd0, i2c_data}, 32'd0);
    chk({tag, " rst upd_ready"}, {31'd0, upd_ready}, 32'd0);
    chk({tag, " rst done"}, {31'd0, cfg_done}, 32'd0);
    chk({tag, " rst err"}, {31'd0, cfg_err}, 32'd0);
    chk({tag, " rst index"}, {28'd0, cfg_index}, 32'd0);
    att_data.delete();
    att_out.delete();
    att_hi.delete();
    stab_err = 0;
    repeat (3) @(negedge clock_i2c);
    reset_n = 1'b1;
  endtask

  task automatic wait_term(input string tag);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < 8000) begin
      @(negedge clock_i2c);
      n++;
    end
    chk({tag, " finished"}, {31'd0, cfg_done | cfg_err}, 32'd1);
    repeat (5) @(negedge clock_i2c);
  endtask

  // Reference model: walks the table using the outcome the engine gave
  // each attempt and derives the expected data stream and final status.
  task automatic check_run(input string tag);
    int idx = 0, tries = 0, a = 0;
    bit term = 0, dm = 0, em = 0;
    while (a < att_data.size() && !term) begin
      chk($sformatf("%s wr%0d data", tag, a), {8'd0, att_data[a]}, {8'd0, DEV, TBL[idx]});
      if (att_out[a] == TMO)
        chk($sformatf("%s wr%0d start_high_cycles", tag, a), 32'(att_hi[a]), 32'(XFER_TIMEOUT));
      if (att_out[a] == OK) begin
        idx++;
        tries = 0;
        if (idx == NUM_REGS) begin term = 1; dm = 1; end
      end else begin
        tries++;
        if (tries > RETRIES) begin term = 1; em = 1; end
      end
      a++;
    end
    chk({tag, " write_count"}, 32'(att_data.size()), 32'(a));
    chk({tag, " done"}, {31'd0, cfg_done}, {31'd0, dm});
    chk({tag, " err"}, {31'd0, cfg_err}, {31'd0, em});
    chk({tag, " upd_ready"}, {31'd0, upd_ready}, {31'd0, dm});
    chk({tag, " start_idle"}, {31'd0, i2c_start}, 32'd0);
    chk({tag, " data_stable"}, 32'(stab_err), 32'd0);
  endtask

  task automatic run_cfg(input string tag);
    do_reset(tag);
    // A request during power-up wait must be ignored.
    repeat (20) @(negedge clock_i2c);
    upd_data  = 16'hABCD;
    upd_valid = 1'b1;
    @(negedge clock_i2c);
    upd_valid = 1'b0;
    wait_term(tag);
    check_run(tag);
  endtask

  // ---------------- directed scenario table ----------------
  typedef struct {
    logic [15:0] tgt;
    int          kind;
    int          times;
    int          lat;
    int          exp_wr;
    bit          exp_done;
    bit          exp_err;
    logic [23:0] exp_last;
  } row_t;

  row_t rows[5];

  initial begin
    int n;
    string tag;

    rows[0] = '{16'h0812, NACK, 0,    34, 11, 1'b1, 1'b0, 24'h341201};
    rows[1] = '{16'h0812, NACK, 1,    20, (RETRIES > 0) ? 12 : 6, RETRIES > 0, RETRIES == 0,
                (RETRIES > 0) ? 24'h341201 : 24'h340812};
    rows[2] = '{16'h0812, NACK, 1000, 30, 5 + RETRIES + 1, 1'b0, 1'b1, 24'h340812};
    rows[3] = '{16'h1E00, TMO,  1000, 34, RETRIES + 1, 1'b0, 1'b1, 24'h341E00};
    rows[4] = '{16'h1201, TMO,  1,    34, (RETRIES > 0) ? 12 : 11, RETRIES > 0, RETRIES == 0, 24'h341201};

    for (int i = 0; i < 5; i++) begin
      tag       = $sformatf("row%0d", i);
      rand_mode = 0;
      tgt_word  = rows[i].tgt;
      tgt_kind  = rows[i].kind;
      tgt_left  = rows[i].times;
      fix_lat   = rows[i].lat;
      run_cfg(tag);
      chk({tag, " writes"}, 32'(att_data.size()), 32'(rows[i].exp_wr));
      chk({tag, " done_flag"}, {31'd0, cfg_done}, {31'd0, rows[i].exp_done});
      chk({tag, " err_flag"}, {31'd0, cfg_err}, {31'd0, rows[i].exp_err});
      chk({tag, " last_data"}, (att_data.size() > 0) ? {8'd0, att_data[att_data.size()-1]} : 32'hFFFF_FFFF,
          {8'd0, rows[i].exp_last});
      $display("row%0d: %0d writes, done=%0b err=%0b", i, att_data.size(), cfg_done, cfg_err);
    end

    // ---------------- runtime update from DONE ----------------
    rand_mode = 0; tgt_left = 0; fix_lat = 34;
    run_cfg("upd_base");
    att_data.delete(); att_out.delete(); att_hi.delete();
    @(negedge clock_i2c);
    upd_data  = 16'h0479;
    upd_valid = 1'b1;
    @(negedge clock_i2c);
    upd_valid = 1'b0;
    chk("upd ready_drops", {31'd0, upd_ready}, 32'd0);
    // Acceptance edge was the posedge just passed; count edges to start.
    n = 0;
    do begin
      @(posedge clock_i2c);
      n++;
      #1;
    end while (!i2c_start && n < 20);
    chk("upd start_latency", 32'(n), 32'd3);
    @(negedge clock_i2c);
    upd_data  = 16'h0A5A;
    upd_valid = 1'b1;
    @(negedge clock_i2c);
    upd_valid = 1'b0;
    n = 0;
    while (!upd_ready && n < 200) begin
      @(negedge clock_i2c);
      n++;
    end
    chk("upd back_to_done", {31'd0, upd_ready}, 32'd1);
    repeat (100) @(negedge clock_i2c);
    chk("upd write_count", 32'(att_data.size()), 32'd1);
    chk("upd data", (att_data.size() > 0) ? {8'd0, att_data[0]} : 32'hFFFF_FFFF, 32'h0034_0479);
    chk("upd done_kept", {31'd0, cfg_done}, 32'd1);
    chk("upd err", {31'd0, cfg_err}, 32'd0);
    $display("update: %0d writes, upd_ready=%0b", att_data.size(), upd_ready);

    // ---------------- reset during the write of entry 6 ----------------
    do_reset("mid");
    n = 0;
    while (att_data.size() < 7 && n < 5000) begin
      @(negedge clock_i2c);
      n++;
    end
    repeat (5) @(negedge clock_i2c);
    chk("mid in_flight", {31'd0, i2c_start}, 32'd1);
    chk("mid in_flight_data", {8'd0, i2c_data}, {8'd0, DEV, TBL[6]});
    do_reset("mid2");
    n = 0;
    do begin
      @(posedge clock_i2c);
      n++;
      #1;
    end while (!i2c_start && n < 3000);
    chk("mid restart_latency", 32'(n), 32'(PWR_DLY + 3));
    wait_term("mid");
    check_run("mid");
    $display("midreset: restart after %0d cycles, %0d writes", n, att_data.size());

    // ---------------- randomized engine outcomes ----------------
    rand_mode = 1;
    for (int r = 0; r < 6; r++) begin
      tag = $sformatf("rand%0d", r);
      run_cfg(tag);
      $display("%s: %0d writes, done=%0b err=%0b", tag, att_data.size(), cfg_done, cfg_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
